// File: rtl/fix_div_seq.sv
// Sequential signed fixed-point divider, out = a / b on Q(N-F).F operands.
// Restoring radix-2 long division on magnitudes, one quotient bit per cycle,
// followed by a single finalise edge that applies sign and saturation.
// Divide-by-zero short-circuits straight to the result state.
module fix_div_seq #(
    parameter int N = 32,
    parameter int F = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int W  = N + F;
    localparam int CW = $clog2(W + 1);

    // Saturation limits for the result and the matching quotient-magnitude bounds.
    localparam logic [N-1:0] OUT_MAX   = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] OUT_MIN   = {1'b1, {(N-1){1'b0}}};
    localparam logic [W-1:0] Q_MAX     = {{(F+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [W-1:0] Q_MIN_MAG = {{F{1'b0}}, 1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic            sign_r;      // result sign, a[msb] ^ b[msb]
    logic [N-1:0]    abs_b_r;     // divisor magnitude
    logic [W-1:0]    d_r;         // dividend magnitude << F, consumed from the msb
    logic [N-1:0]    rem_r;       // partial remainder; always < |b| <= 2^(N-1), so N bits suffice
    logic [W-1:0]    q_r;         // quotient magnitude
    logic [CW-1:0]   cnt_r;       // remaining iterations minus one
    logic            fin_r;       // last iteration done, next CALC edge finalises
    logic [N-1:0]    out_r;
    logic            dbz_r;
    logic            ovf_r;
    logic            out_valid_r;

    logic [N:0]      rem_shift_s;
    logic [N:0]      diff_s;
    logic [N-1:0]    rem_nxt_s;
    logic            q_bit_s;
    logic [N-1:0]    fin_out_s;
    logic            fin_ovf_s;
    logic            accept_s;
    logic            b_zero_s;

    // Two's-complement magnitude; the most negative value maps to 2^(N-1) unsigned.
    function automatic logic [N-1:0] mag(input logic [N-1:0] v);
        logic [N-1:0] m;
        if (v[N-1]) begin
            m = ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    assign in_ready    = (state_r == IDLE);
    assign accept_s    = in_valid && (state_r == IDLE);
    assign b_zero_s    = (b == {N{1'b0}});
    assign out         = out_r;
    assign div_by_zero = dbz_r;
    assign overflow    = ovf_r;
    assign out_valid   = out_valid_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (b_zero_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (fin_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, trial-subtract |b|.
    // The borrow out of the N+1-bit subtraction is the "R' < |b|" decision.
    always_comb begin
        rem_shift_s = {rem_r, d_r[W-1]};
        diff_s      = rem_shift_s - {1'b0, abs_b_r};
        if (!diff_s[N]) begin
            rem_nxt_s = diff_s[N-1:0];
            q_bit_s   = 1'b1;
        end else begin
            rem_nxt_s = rem_shift_s[N-1:0];
            q_bit_s   = 1'b0;
        end
    end

    // Sign application and saturation of the finished quotient magnitude.
    always_comb begin
        fin_out_s = OUT_MAX;
        fin_ovf_s = 1'b0;
        if (!sign_r && (q_r > Q_MAX)) begin
            fin_out_s = OUT_MAX;
            fin_ovf_s = 1'b1;
        end else if (sign_r && (q_r > Q_MIN_MAG)) begin
            fin_out_s = OUT_MIN;
            fin_ovf_s = 1'b1;
        end else begin
            if (sign_r) begin
                fin_out_s = ~q_r[N-1:0] + {{(N-1){1'b0}}, 1'b1};
            end else begin
                fin_out_s = q_r[N-1:0];
            end
            fin_ovf_s = 1'b0;
        end
    end

    // Datapath and registered outputs: operand capture, iteration, finalise, handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r      <= 1'b0;
            abs_b_r     <= {N{1'b0}};
            d_r         <= {W{1'b0}};
            rem_r       <= {N{1'b0}};
            q_r         <= {W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            fin_r       <= 1'b0;
            out_r       <= {N{1'b0}};
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sign_r  <= a[N-1] ^ b[N-1];
                        abs_b_r <= mag(b);
                        d_r     <= {mag(a), {F{1'b0}}};
                        rem_r   <= {N{1'b0}};
                        q_r     <= {W{1'b0}};
                        cnt_r   <= CNT_LAST;
                        fin_r   <= 1'b0;
                        if (b_zero_s) begin
                            out_r       <= a[N-1] ? OUT_MIN : OUT_MAX;
                            dbz_r       <= 1'b1;
                            ovf_r       <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (fin_r) begin
                        out_r       <= fin_out_s;
                        ovf_r       <= fin_ovf_s;
                        dbz_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        fin_r       <= 1'b0;
                    end else begin
                        rem_r <= rem_nxt_s;
                        q_r   <= {q_r[W-2:0], q_bit_s};
                        d_r   <= {d_r[W-2:0], 1'b0};
                        fin_r <= (cnt_r == {CW{1'b0}});
                        if (cnt_r != {CW{1'b0}}) begin
                            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
